// File: rtl/sync_ram.sv
// Single-port synchronous RAM with write-first registered read data.
// Every word is held at zero while rst is high; out-of-range addresses read as zero and ignore writes.
module sync_ram #(
   parameter int unsigned N = 8,
   parameter int unsigned M = 32,
   localparam int unsigned AddrSz = $clog2(M)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AddrSz-1:0] addr,
   input  logic [N-1:0]      w_data,
   input  logic              w_en,
   output logic [N-1:0]      r_data
);

   logic [N-1:0] mem_q [M];
   logic [N-1:0] mem_d [M];
   logic [N-1:0] r_data_q;
   logic [N-1:0] r_data_d;
   logic         addr_ok_c;

   // Addresses at or beyond M exist only when M is not a power of two.
   assign addr_ok_c = (32'(addr) < 32'(M));

   // Next-state for storage and read register.
   always_comb begin
      mem_d    = mem_q;
      r_data_d = '0;
      if (addr_ok_c) begin
         if (w_en) begin
            mem_d[addr] = w_data;
            r_data_d    = w_data;
         end else begin
            r_data_d    = mem_q[addr];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(M); i++) begin
            mem_q[i] <= '0;
         end
         r_data_q <= '0;
      end else begin
         mem_q    <= mem_d;
         r_data_q <= r_data_d;
      end
   end

   assign r_data = r_data_q;

endmodule

// File: tb/tb_sync_ram.sv
// Self-checking bench for sync_ram: directed scenarios plus random traffic
// compared every cycle against an array-based reference memory.
module tb_sync_ram;

   localparam int unsigned N = 8;
   localparam int unsigned M = 32;
   localparam int unsigned AW = $clog2(M);

   logic          clk;
   logic          rst;
   logic [AW-1:0] addr;
   logic [N-1:0]  w_data;
   logic          w_en;
   logic [N-1:0]  r_data;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   logic [N-1:0] ref_mem [M];
   logic [N-1:0] ref_r;

   sync_ram #(.N(N), .M(M)) dut (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr),
      .w_data (w_data),
      .w_en   (w_en),
      .r_data (r_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: r_data=%0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference: a plain array plus the value a read at this edge must return.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(M); i++) ref_mem[i] = '0;
         ref_r = '0;
      end else if (w_en) begin
         ref_mem[addr] = w_data;
         ref_r = w_data;
      end else begin
         ref_r = ref_mem[addr];
      end
   end

   always @(negedge clk) begin
      if (chk_en) check("model", r_data, ref_r);
   end

   // Drive one cycle of inputs and return at the following falling edge.
   task automatic step(input logic we, input logic [AW-1:0] a, input logic [N-1:0] d);
      w_en   = we;
      addr   = a;
      w_data = d;
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] rd;
      logic [AW-1:0] ra;
      rst = 1'b1; w_en = 1'b0; addr = '0; w_data = '0;
      repeat (2) @(negedge clk);
      check("reset_value", r_data, 8'h00);
      rst = 1'b0;
      chk_en = 1'b1;

      // Every address reads zero after reset.
      for (int a = 0; a < int'(M); a++) begin
         step(1'b0, AW'(a), 8'h00);
         check("post_reset_read", r_data, 8'h00);
      end

      // Write-first, then held address returns the written value.
      step(1'b1, 5'd12, 8'd136);
      check("write_first", r_data, 8'd136);
      step(1'b0, 5'd12, 8'h00);
      check("read_after_write", r_data, 8'd136);

      step(1'b1, 5'd2, 8'd32);
      check("write_addr2", r_data, 8'd32);
      step(1'b0, 5'd12, 8'h00);
      check("read_addr12", r_data, 8'd136);
      step(1'b0, 5'd2, 8'h00);
      check("read_addr2", r_data, 8'd32);

      // Back-to-back overwrite of one word leaves neighbours alone.
      step(1'b1, 5'd5, 8'hAA);
      step(1'b1, 5'd5, 8'h55);
      step(1'b0, 5'd5, 8'h00);
      check("overwrite", r_data, 8'h55);
      step(1'b0, 5'd4, 8'h00);
      check("neighbour4", r_data, 8'h00);
      step(1'b0, 5'd6, 8'h00);
      check("neighbour6", r_data, 8'h00);
      step(1'b0, 5'd12, 8'h00);
      check("other_word", r_data, 8'd136);

      // A write-enable pulse between edges must not be captured.
      w_en = 1'b0; addr = 5'd3; w_data = 8'h5A;
      #1 w_en = 1'b1;
      #1 w_en = 1'b0;
      @(negedge clk);
      step(1'b0, 5'd3, 8'h00);
      check("glitch_ignored", r_data, 8'h00);

      // Property: write then hold address and data with w_en low.
      step(1'b1, 5'd20, 8'h3C);
      step(1'b0, 5'd20, 8'h3C);
      check("hold_after_write", r_data, 8'h3C);

      // Asynchronous reset mid-cycle after a write.
      step(1'b1, 5'd7, 8'hFF);
      check("write_ff", r_data, 8'hFF);
      w_en = 1'b0;
      #2 rst = 1'b1;
      #1 check("async_clear", r_data, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 5'd7, 8'h00);
      check("addr7_after_reset", r_data, 8'h00);
      step(1'b0, 5'd12, 8'h00);
      check("addr12_after_reset", r_data, 8'h00);

      // Reset coinciding with a write edge wins.
      step(1'b1, 5'd9, 8'h11);
      w_en = 1'b1; addr = 5'd9; w_data = 8'h33;
      #3 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 5'd9, 8'h00);
      check("reset_beats_write", r_data, 8'h00);

      // Random traffic; the compare process checks every cycle.
      for (int i = 0; i < 500; i++) begin
         ra = AW'($urandom_range(M - 1, 0));
         rd = N'($urandom);
         step(1'($urandom_range(1, 0)), ra, rd);
      end

      // Random write/hold pairs.
      for (int i = 0; i < 20; i++) begin
         ra = AW'($urandom_range(M - 1, 0));
         rd = N'($urandom);
         step(1'b1, ra, rd);
         step(1'b0, ra, rd);
         check("rand_hold", r_data, rd);
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
